// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store/stack unit over a byte-wide data memory.
// Every word access is split into four little-endian byte beats.
// Optional feature: define STACK_GUARD_EN to enable stack depth tracking
// with overflow/underflow rejection.
module mem_access_unit #(
    parameter int unsigned STACK_WORDS = 64,
    parameter logic [9:0]  SP_RESET    = 10'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [9:0]  sp_out,
    output logic [9:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);

    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000100;
    localparam logic [5:0] OP_PUSH = 6'b001111;
    localparam logic [5:0] OP_POP  = 6'b010000;
    localparam logic [5:0] OP_CALL = 6'b000110;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

    state_t      state_q, state_d;
    logic [9:0]  sp_q;
    logic [9:0]  base_q;
    logic [31:0] data_q;
    logic [1:0]  beat_q;
    logic [23:0] rbuf_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        accept;
    logic        addr_ok;
    logic        stack_full;
    logic        stack_empty;
    logic        acc_err;
    logic        acc_wr;
    logic        acc_rd;
    logic        acc_push;
    logic        acc_pop;
    logic [9:0]  acc_base;
    logic [31:0] acc_data;

`ifdef STACK_GUARD_EN
    localparam int unsigned DEPTH_W = $clog2(STACK_WORDS + 1);
    logic [DEPTH_W-1:0] depth_q;

    // Stack guard: occupancy limits
    always_comb begin
        stack_full  = (depth_q == DEPTH_W'(STACK_WORDS));
        stack_empty = (depth_q == '0);
    end

    // Stack depth counter, follows every accepted push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else if (accept && acc_push) begin
            depth_q <= depth_q + 1'b1;
        end else if (accept && acc_pop) begin
            depth_q <= depth_q - 1'b1;
        end
    end
`else
    // No depth tracking: the stack pointer simply wraps
    always_comb begin
        stack_full  = 1'b0;
        stack_empty = 1'b0;
    end
`endif

    assign accept = req_valid && (state_q == IDLE);

    // Request decode: classify the op and compute the word base address/data.
    // The derived base/data are captured instead of the raw request fields.
    always_comb begin
        addr_ok  = (addr[1:0] == 2'b00) && (addr[31:10] == '0);
        acc_err  = 1'b1;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        acc_push = 1'b0;
        acc_pop  = 1'b0;
        acc_base = '0;
        acc_data = '0;
        case (opcode)
            OP_LW: begin
                acc_err  = !addr_ok;
                acc_rd   = addr_ok;
                acc_base = addr[9:0];
            end
            OP_SW: begin
                acc_err  = !addr_ok;
                acc_wr   = addr_ok;
                acc_base = addr[9:0];
                acc_data = wdata;
            end
            OP_PUSH, OP_CALL: begin
                acc_err  = stack_full;
                acc_wr   = !stack_full;
                acc_push = !stack_full;
                acc_base = sp_q - 10'd4;
                acc_data = (opcode == OP_CALL) ? (pc + 32'd4) : wdata;
            end
            OP_POP: begin
                acc_err  = stack_empty;
                acc_rd   = !stack_empty;
                acc_pop  = !stack_empty;
                acc_base = sp_q;
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_err)     state_d = RESP;
                    else if (acc_wr) state_d = WRITE;
                    else             state_d = READ;
                end
            end
            WRITE:   if (beat_q == 2'd3) state_d = RESP;
            READ:    if (beat_q == 2'd3) state_d = DRAIN;
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: request capture, beat counter, read assembly, response and SP.
    // Read bytes arrive one cycle late, so byte k is captured during beat k+1
    // and the last byte during DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= SP_RESET;
            base_q     <= '0;
            data_q     <= '0;
            beat_q     <= '0;
            rbuf_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        base_q <= acc_base;
                        data_q <= acc_data;
                        beat_q <= '0;
                        if (acc_err) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                        end
                        if (acc_push) sp_q <= sp_q - 10'd4;
                        if (acc_pop)  sp_q <= sp_q + 10'd4;
                    end
                end
                WRITE: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        rsp_err_q  <= 1'b0;
                        rsp_data_q <= '0;
                    end
                end
                READ: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q != 2'd0) rbuf_q <= {mem_rdata, rbuf_q[23:8]};
                end
                DRAIN: begin
                    rsp_err_q  <= 1'b0;
                    rsp_data_q <= {mem_rdata, rbuf_q};
                end
                default: ;
            endcase
        end
    end

    // Output decode; strobes are only ever active during beats
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        sp_out    = sp_q;
        mem_we    = (state_q == WRITE);
        mem_re    = (state_q == READ);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_we || mem_re) mem_addr = base_q + {8'd0, beat_q};
        if (mem_we)           mem_wdata = data_q[8*beat_q +: 8];
    end

endmodule
